// File: rtl/mac_rx_pkg.sv
// Shared definitions for the RX MAC frame checker: XGMII code points,
// CRC-32 constants, FSM state encoding, verdict payload and a bytewise CRC step.
package mac_rx_pkg;

  localparam logic [7:0] CODE_IDLE     = 8'h07;
  localparam logic [7:0] CODE_START    = 8'hFB;
  localparam logic [7:0] CODE_TERM     = 8'hFD;
  localparam logic [7:0] CODE_PREAMBLE = 8'h55;
  localparam logic [7:0] CODE_SFD      = 8'hD5;

  localparam logic [31:0] CRC_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_ABORT = 2'd2
  } rx_chk_state_t;

  // Per-frame error flags reported with the done pulse.
  typedef struct packed {
    logic fmt;
    logic fcs;
    logic len;
    logic da;
  } rx_verdict_t;

  // One byte of reflected CRC-32 (LSB-first), no final inversion.
  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int unsigned k = 0; k < 8; k++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/mac_crc32_lanes.sv
// Combinational CRC-32 update over the masked byte lanes of one beat, lane 0 first.
// Ports: crc_in (running CRC), data (lane bytes), lane_mask (1 = lane is a frame
// byte), crc_out (CRC after all masked lanes).
module mac_crc32_lanes
  import mac_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic [31:0]             crc_in,
  input  logic [DATA_WIDTH-1:0]   data,
  input  logic [DATA_WIDTH/8-1:0] lane_mask,
  output logic [31:0]             crc_out
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  always_comb begin
    crc_out = crc_in;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (lane_mask[i]) crc_out = crc32_byte(crc_out, data[8*i +: 8]);
    end
  end

endmodule

// File: rtl/mac_rx_frame_checker.sv
// Receive-side frame checker on an XGMII-style lane bus. Passively watches the
// bus, tracks each frame from START to TERM and reports a registered verdict.
// Ports: clk, i_rst_n (async active-low); i_rx_valid/i_rx_data/i_rx_ctrl beat
// input; o_frame_done pulse with o_frame_good, o_fcs_error, o_len_error,
// o_format_error, o_da_error and o_frame_len; o_good_cnt/o_bad_cnt statistics.
module mac_rx_frame_checker
  import mac_rx_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 64,
  parameter int unsigned CTRL_WIDTH     = DATA_WIDTH / 8,
  parameter int unsigned MIN_FRAME_SIZE = 64,
  parameter int unsigned MAX_FRAME_SIZE = 1518,
  parameter bit          CHECK_DA       = 1'b0,
  parameter logic [47:0] DST_ADDR_CODE  = 48'h0180C2000001,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_rx_valid,
  input  logic [DATA_WIDTH-1:0] i_rx_data,
  input  logic [CTRL_WIDTH-1:0] i_rx_ctrl,
  output logic                  o_frame_done,
  output logic                  o_frame_good,
  output logic                  o_fcs_error,
  output logic                  o_len_error,
  output logic                  o_format_error,
  output logic                  o_da_error,
  output logic [15:0]           o_frame_len,
  output logic [CNT_WIDTH-1:0]  o_good_cnt,
  output logic [CNT_WIDTH-1:0]  o_bad_cnt
);

  localparam int unsigned LANES = DATA_WIDTH / 8;

  rx_chk_state_t        state_q, state_d;
  logic [31:0]          crc_q, crc_d;
  logic [15:0]          acc_len_q, acc_len_d;
  logic                 acc_da_q, acc_da_d;
  logic                 done_q, done_d;
  logic                 good_q, good_d;
  rx_verdict_t          verdict_q, verdict_d;
  logic [15:0]          frame_len_q, frame_len_d;
  logic [CNT_WIDTH-1:0] good_cnt_q, good_cnt_d;
  logic [CNT_WIDTH-1:0] bad_cnt_q, bad_cnt_d;

  logic             start_c, pre_ok_c, ctl_found_c, term_ok_c, all_idle_c, any_term_c;
  int unsigned      scan_lo_c, ctl_lane_c;
  logic [LANES-1:0] frame_mask_c;
  logic [31:0]      crc_base_c, crc_next_c;
  logic [16:0]      len_cnt_c;
  logic [15:0]      len_next_c;
  logic             da_mis_c;
  logic             rep_v;
  rx_verdict_t      rep;
  logic [15:0]      rep_len;
  logic             do_start, step;

  // Expected DA byte k in wire order (most significant byte first).
  function automatic logic [7:0] da_byte(input logic [2:0] k);
    case (k)
      3'd0:    return DST_ADDR_CODE[47:40];
      3'd1:    return DST_ADDR_CODE[39:32];
      3'd2:    return DST_ADDR_CODE[31:24];
      3'd3:    return DST_ADDR_CODE[23:16];
      3'd4:    return DST_ADDR_CODE[15:8];
      default: return DST_ADDR_CODE[7:0];
    endcase
  endfunction

  // Beat decode: start/preamble, first control lane, terminate shape, frame lanes.
  always_comb begin
    start_c  = i_rx_ctrl[0] && (i_rx_data[7:0] == CODE_START);
    pre_ok_c = 1'b1;
    for (int unsigned i = 1; i < 8; i++) begin
      if (i_rx_ctrl[i] || (i_rx_data[8*i +: 8] != ((i == 7) ? CODE_SFD : CODE_PREAMBLE)))
        pre_ok_c = 1'b0;
    end
    // In a start beat the first 8 lanes are START/preamble/SFD, frame bytes follow.
    scan_lo_c   = start_c ? 8 : 0;
    ctl_found_c = 1'b0;
    ctl_lane_c  = 0;
    all_idle_c  = 1'b1;
    any_term_c  = 1'b0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (!ctl_found_c && i >= scan_lo_c && i_rx_ctrl[i]) begin
        ctl_found_c = 1'b1;
        ctl_lane_c  = i;
      end
      if (!i_rx_ctrl[i] || i_rx_data[8*i +: 8] != CODE_IDLE) all_idle_c = 1'b0;
      if (i_rx_ctrl[i] && i_rx_data[8*i +: 8] == CODE_TERM) any_term_c = 1'b1;
    end
    term_ok_c = ctl_found_c && (i_rx_data[8*ctl_lane_c +: 8] == CODE_TERM);
    for (int unsigned i = 0; i < LANES; i++) begin
      if (ctl_found_c && i > ctl_lane_c &&
          (!i_rx_ctrl[i] || i_rx_data[8*i +: 8] != CODE_IDLE))
        term_ok_c = 1'b0;
      frame_mask_c[i] = (i >= scan_lo_c) && (!ctl_found_c || i < ctl_lane_c);
    end
  end

  // Running length and DA comparison, restarted on a start beat.
  always_comb begin
    len_cnt_c = start_c ? 17'd0 : 17'(acc_len_q);
    da_mis_c  = start_c ? 1'b0 : acc_da_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (frame_mask_c[i]) begin
        if (len_cnt_c < 17'd6 && i_rx_data[8*i +: 8] != da_byte(3'(len_cnt_c)))
          da_mis_c = 1'b1;
        len_cnt_c = len_cnt_c + 17'd1;
      end
    end
    len_next_c = (len_cnt_c > 17'h0FFFF) ? 16'hFFFF : 16'(len_cnt_c);
  end

  assign crc_base_c = start_c ? CRC_INIT : crc_q;

  mac_crc32_lanes #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_crc (
    .crc_in    (crc_base_c),
    .data      (i_rx_data),
    .lane_mask (frame_mask_c),
    .crc_out   (crc_next_c)
  );

  // Next state and verdict selection. A START inside a frame reports the old
  // frame; the new frame's own verdict in that same beat would collide and is dropped.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    acc_len_d = acc_len_q;
    acc_da_d  = acc_da_q;
    rep_v     = 1'b0;
    rep       = '0;
    rep_len   = '0;
    do_start  = 1'b0;
    step      = 1'b0;
    if (i_rx_valid) begin
      unique case (state_q)
        ST_IDLE: do_start = start_c;
        ST_DATA: begin
          if (start_c) begin
            rep_v    = 1'b1;
            rep.fmt  = 1'b1;
            rep_len  = acc_len_q;
            do_start = 1'b1;
          end else begin
            step = 1'b1;
          end
        end
        ST_ABORT: begin
          if (start_c) do_start = 1'b1;
          else if (any_term_c || all_idle_c) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
      if (do_start) begin
        if (pre_ok_c) begin
          step = 1'b1;
        end else begin
          state_d = ST_ABORT;
          if (!rep_v) begin
            rep_v   = 1'b1;
            rep.fmt = 1'b1;
          end
        end
      end
      if (step) begin
        if (!ctl_found_c) begin
          state_d   = ST_DATA;
          crc_d     = crc_next_c;
          acc_len_d = len_next_c;
          acc_da_d  = da_mis_c;
        end else begin
          state_d = term_ok_c ? ST_IDLE : ST_ABORT;
          if (!rep_v) begin
            rep_v   = 1'b1;
            rep_len = len_next_c;
            if (term_ok_c) begin
              rep.fcs = (crc_next_c != CRC_RESIDUE);
              rep.len = (32'(len_next_c) < MIN_FRAME_SIZE) || (32'(len_next_c) > MAX_FRAME_SIZE);
              rep.da  = CHECK_DA && da_mis_c;
            end else begin
              rep.fmt = 1'b1;
            end
          end
        end
      end
    end
  end

  // Verdict hold and saturating statistics.
  always_comb begin
    done_d      = rep_v;
    verdict_d   = verdict_q;
    good_d      = good_q;
    frame_len_d = frame_len_q;
    good_cnt_d  = good_cnt_q;
    bad_cnt_d   = bad_cnt_q;
    if (rep_v) begin
      verdict_d   = rep;
      frame_len_d = rep_len;
      good_d      = ~(rep.fmt | rep.fcs | rep.len | rep.da);
      if (good_d) begin
        if (good_cnt_q != {CNT_WIDTH{1'b1}}) good_cnt_d = good_cnt_q + CNT_WIDTH'(1);
      end else begin
        if (bad_cnt_q != {CNT_WIDTH{1'b1}}) bad_cnt_d = bad_cnt_q + CNT_WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= ST_IDLE;
      crc_q       <= CRC_INIT;
      acc_len_q   <= '0;
      acc_da_q    <= 1'b0;
      done_q      <= 1'b0;
      good_q      <= 1'b0;
      verdict_q   <= '0;
      frame_len_q <= '0;
      good_cnt_q  <= '0;
      bad_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      acc_len_q   <= acc_len_d;
      acc_da_q    <= acc_da_d;
      done_q      <= done_d;
      good_q      <= good_d;
      verdict_q   <= verdict_d;
      frame_len_q <= frame_len_d;
      good_cnt_q  <= good_cnt_d;
      bad_cnt_q   <= bad_cnt_d;
    end
  end

  assign o_frame_done   = done_q;
  assign o_frame_good   = good_q;
  assign o_fcs_error    = verdict_q.fcs;
  assign o_len_error    = verdict_q.len;
  assign o_format_error = verdict_q.fmt;
  assign o_da_error     = verdict_q.da;
  assign o_frame_len    = frame_len_q;
  assign o_good_cnt     = good_cnt_q;
  assign o_bad_cnt      = bad_cnt_q;

endmodule
